// File: rtl/argument_encoder.sv
`default_nettype none
// ============================================================================
// Module   : argument_encoder
// Brief    : Packs variable-length codes LSB-first into WIDTH_OUT-bit words
//            held in a small FWFT FIFO. A flush zero-pads the partial word.
//            Optional bit counter: define ARGUMENT_ENCODER_BIT_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module argument_encoder #(
    parameter int WIDTH_IN      = 64,
    parameter int WIDTH_OUT     = 64,
    parameter int LOG2_WIDTH_IN = $clog2(WIDTH_IN),
    parameter int BUFFER_WIDTH  = WIDTH_OUT + WIDTH_IN,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH_IN-1:0]      d,
    input  logic [LOG2_WIDTH_IN:0]   len,
    input  logic                     flush,
    output logic                     full,
    output logic [WIDTH_OUT-1:0]     q,
    output logic                     empty,
    input  logic                     pop,
`ifdef ARGUMENT_ENCODER_BIT_COUNT_EN
    output logic [31:0]              bit_count,
`endif
    output logic                     idle
);

    localparam int LEN_W = LOG2_WIDTH_IN + 1;
    localparam int CNT_W = $clog2(BUFFER_WIDTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] c_word_cnt = CNT_W'(WIDTH_OUT);
    localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(WIDTH_IN);
    localparam logic [OCC_W-1:0] c_fifo_max = OCC_W'(FIFO_DEPTH);

    localparam logic [0:0] S_ACCEPT = 1'b0;
    localparam logic [0:0] S_FLUSH  = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [BUFFER_WIDTH-1:0] r_acc;
    logic [BUFFER_WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_nxt;

    logic [WIDTH_OUT-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [OCC_W-1:0]        r_occ;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_fifo_wr;
    logic                    w_fifo_rd;
    logic [WIDTH_OUT-1:0]    w_fifo_wdata;

    logic [LEN_W-1:0]        w_len_eff;
    logic [WIDTH_IN:0]       w_mask_full;
    logic [BUFFER_WIDTH-1:0] w_code_ext;
    logic                    w_full;
    logic                    w_push_ok;
    logic                    w_flush_ok;

    // Over-long lengths clamp to WIDTH_IN; the mask is built one bit wider
    // so that a full-width code yields an all-ones mask without overflow.
    assign w_len_eff   = (len > c_max_len) ? c_max_len : len;
    assign w_mask_full = ~({(WIDTH_IN + 1){1'b1}} << w_len_eff);
    assign w_code_ext  = {{WIDTH_OUT{1'b0}}, d & w_mask_full[WIDTH_IN-1:0]};

    assign w_fifo_full  = (r_occ == c_fifo_max);
    assign w_fifo_empty = (r_occ == '0);
    assign w_full       = (r_count >= c_word_cnt) || (r_state == S_FLUSH);
    assign w_push_ok    = push && !w_full;
    assign w_flush_ok   = flush && !w_full;
    assign w_fifo_rd    = pop && !w_fifo_empty;

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_count_nxt  = r_count;
        w_fifo_wr    = 1'b0;
        w_fifo_wdata = r_acc[WIDTH_OUT-1:0];
        if (r_count >= c_word_cnt) begin
            if (!w_fifo_full) begin
                w_fifo_wr   = 1'b1;
                w_acc_nxt   = r_acc >> WIDTH_OUT;
                w_count_nxt = r_count - c_word_cnt;
            end
        end else if (r_state == S_FLUSH) begin
            if (r_count == '0) begin
                w_state_nxt = S_ACCEPT;
            end else if (!w_fifo_full) begin
                // Bits above count are already zero, so the word is padded.
                w_fifo_wr   = 1'b1;
                w_acc_nxt   = '0;
                w_count_nxt = '0;
                w_state_nxt = S_ACCEPT;
            end
        end else begin
            if (w_push_ok) begin
                w_acc_nxt   = r_acc | (w_code_ext << r_count);
                w_count_nxt = r_count + CNT_W'(w_len_eff);
            end
            if (w_flush_ok) begin
                w_state_nxt = S_FLUSH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACCEPT;
            r_acc   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_fifo_wr && !w_fifo_rd) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_fifo_wr && w_fifo_rd) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= w_fifo_wdata;
        end
    end

`ifdef ARGUMENT_ENCODER_BIT_COUNT_EN
    logic [31:0] r_bit_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_count <= '0;
        end else if (w_push_ok) begin
            r_bit_count <= r_bit_count + 32'(w_len_eff);
        end
    end

    assign bit_count = r_bit_count;
`endif

    assign full  = w_full;
    assign empty = w_fifo_empty;
    assign q     = w_fifo_empty ? '0 : r_mem[r_rd_ptr];
    assign idle  = (r_count == '0) && (r_state == S_ACCEPT) && w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_argument_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_argument_encoder
// Brief    : Scoreboard bench for argument_encoder (64-bit in/out, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_argument_encoder;

    logic        clk;
    logic        rst;
    logic        push;
    logic [63:0] d;
    logic [6:0]  len;
    logic        flush;
    logic        full;
    logic [63:0] q;
    logic        empty;
    logic        pop;
    logic        idle;
`ifdef ARGUMENT_ENCODER_BIT_COUNT_EN
    logic [31:0] bit_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    argument_encoder dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .d     (d),
        .len   (len),
        .flush (flush),
        .full  (full),
        .q     (q),
        .empty (empty),
        .pop   (pop),
`ifdef ARGUMENT_ENCODER_BIT_COUNT_EN
        .bit_count (bit_count),
`endif
        .idle  (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_code(input logic [63:0] dv, input logic [6:0] lv);
        int guard;
        guard = 0;
        while (full && guard < 50) begin
            tick();
            guard++;
        end
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL push_wait full=%b required 0", full);
        end
        push = 1'b1; d = dv; len = lv;
        tick();
        push = 1'b0; d = '0; len = '0;
    endtask

    task automatic pop_check(input string name);
        int guard;
        logic [63:0] exp;
        guard = 0;
        while (empty && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected word q=%h required none", name, q);
        end else begin
            exp = exp_q.pop_front();
            if (empty !== 1'b0 || q !== exp) begin
                errors++;
                $display("FAIL %s empty=%b q=%h required q=%h", name, empty, q, exp);
            end
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || idle !== 1'b1 || q !== 64'h0) begin
            errors++;
            $display("FAIL reset empty=%b full=%b idle=%b q=%h required 1 0 1 0", empty, full, idle, q);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || idle !== 1'b1 || q !== 64'h0) begin
            errors++;
            $display("FAIL pop_empty empty=%b full=%b idle=%b q=%h required 1 0 1 0", empty, full, idle, q);
        end
    endtask

    task automatic test_pack8();
        for (int i = 1; i <= 8; i++) push_code(64'(i), 7'd8);
        exp_q.push_back(64'h0807060504030201);
        checks++;
        if (empty !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL pack8_latency empty=%b full=%b required 1 1", empty, full);
        end
        tick();
        checks++;
        if (empty !== 1'b0) begin
            errors++;
            $display("FAIL pack8_valid empty=%b required 0", empty);
        end
        pop_check("pack8_word");
        checks++;
        if (empty !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL pack8_drain empty=%b idle=%b required 1 1", empty, idle);
        end
    endtask

    task automatic test_mask_flush();
        push_code(64'h0FFFFFFFFFFFFFFF, 7'd60);
        push_code(64'hFFFFFFFFFFFFFFA5, 7'd8);
        exp_q.push_back(64'h5FFFFFFFFFFFFFFF);
        pop_check("mask_word");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.push_back(64'h000000000000000A);
        pop_check("flush_word");
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle idle=%b required 1", idle);
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 1; i <= 5; i++) begin
            push_code(64'(i), 7'd64);
            exp_q.push_back(64'(i));
        end
        tick();
        tick();
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL fifo_stall full=%b required 1", full);
        end
        push = 1'b1; d = 64'd6; len = 7'd64;
        tick();
        push = 1'b0; d = '0; len = '0;
        pop_check("fifo_w1");
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL fifo_after_pop full=%b required 1", full);
        end
        pop_check("fifo_w2");
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL fifo_transfer full=%b required 0", full);
        end
        pop_check("fifo_w3");
        pop_check("fifo_w4");
        pop_check("fifo_w5");
        checks++;
        if (empty !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL fifo_drain empty=%b idle=%b required 1 1", empty, idle);
        end
    endtask

    task automatic test_edge();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (full !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush0_state full=%b empty=%b required 1 1", full, empty);
        end
        tick();
        checks++;
        if (full !== 1'b0 || idle !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush0_accept full=%b idle=%b empty=%b required 0 1 1", full, idle, empty);
        end
        push_code(64'hFF, 7'd0);
        checks++;
        if (full !== 1'b0 || idle !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL len0 full=%b idle=%b empty=%b required 0 1 1", full, idle, empty);
        end
        push = 1'b1; flush = 1'b1; d = 64'h4; len = 7'd4;
        tick();
        push = 1'b0; flush = 1'b0; d = '0; len = '0;
        exp_q.push_back(64'h4);
        pop_check("push_flush");
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL push_flush_idle idle=%b required 1", idle);
        end
    endtask

    task automatic test_random();
        logic [127:0] m_acc;
        int           m_cnt;
        logic [63:0]  rd;
        logic [6:0]   rl;
        int           eff;
        logic [63:0]  masked;
        m_acc = '0;
        m_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            rd = {$urandom, $urandom};
            rl = 7'($urandom_range(0, 80));
            eff = (rl > 7'd64) ? 64 : int'(rl);
            masked = (eff == 64) ? rd : (rd & ((64'd1 << eff) - 64'd1));
            m_acc = m_acc | ({64'd0, masked} << m_cnt);
            m_cnt = m_cnt + eff;
            if (m_cnt >= 64) begin
                exp_q.push_back(m_acc[63:0]);
                m_acc = m_acc >> 64;
                m_cnt = m_cnt - 64;
            end
            push_code(rd, rl);
            if (!empty) pop_check("rand_word");
        end
        flush = 1'b1;
        push_code(64'h0, 7'd0);
        flush = 1'b0;
        if (m_cnt > 0) exp_q.push_back(m_acc[63:0]);
        while (exp_q.size() > 0) pop_check("rand_drain");
        tick();
        checks++;
        if (idle !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rand_idle idle=%b empty=%b required 1 1", idle, empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push_code(64'hDEAD0000 + 64'(i), 7'd64);
        push_code(64'h12345, 7'd40);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre full=%b empty=%b required 1 0", full, empty);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || idle !== 1'b1 || q !== 64'h0) begin
            errors++;
            $display("FAIL midrst empty=%b full=%b idle=%b q=%h required 1 0 1 0", empty, full, idle, q);
        end
        tick();
        tick();
        checks++;
        if (empty !== 1'b1 || q !== 64'h0) begin
            errors++;
            $display("FAIL midrst_stale empty=%b q=%h required 1 0", empty, q);
        end
`ifdef ARGUMENT_ENCODER_BIT_COUNT_EN
        test_pack8();
        checks++;
        if (bit_count !== 32'd64) begin
            errors++;
            $display("FAIL bit_count got=%0d required 64", bit_count);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; d = '0; len = '0; flush = 1'b0; pop = 1'b0;
        test_reset();
        test_pack8();
        test_mask_flush();
        test_fifo_full();
        test_edge();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
